// File: rtl/arb_pkg.sv
// Shared constants and types for the eight-way round-robin arbiter.
// Latency: none; this file declares parameters and types only.
// Backpressure: none; this file declares parameters and types only.
package arb_pkg;

  localparam int NREQ             = 8;
  localparam int IDXW             = 3;
  localparam int DEFAULT_MAX_HOLD = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder: the first set req bit at or above ptr wins, wrapping 7->0.
// Latency: purely combinational.
// Backpressure: none; found=0 when no request is set.
module rr_prio_enc
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic            found
);

  logic [NREQ-1:0] rot;
  logic [IDXW-1:0] off;

  // Rotate right by ptr so the highest-priority requester lands at bit 0.
  always_comb begin
    rot = '0;
    for (int i = 0; i < NREQ; i++) begin
      rot[i] = req[IDXW'(i + int'(ptr))];
    end
  end

  // Fixed lowest-index-first encoder on the rotated vector.
  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = IDXW'(i);
        found = 1'b1;
      end
    end
  end

  // Undo the rotation; the IDXW-bit add wraps mod NREQ.
  assign idx = off + ptr;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for eight requesters; grant held until done (or, with ARB_TIMEOUT_EN, a hold timeout).
// Latency: req sampled at edge t gives a registered grant visible after edge t; done re-arbitrates with no bubble.
// Backpressure: non-owners simply keep req high and wait; the owner cannot be preempted except by the optional timeout.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_vld,
  output logic            timeout
);

  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("rr_arbiter_8: MAX_HOLD must be at least 1");
  end

  state_t          state, state_n;
  logic [IDXW-1:0] ptr, ptr_n;
  logic [NREQ-1:0] gnt_n;
  logic [IDXW-1:0] idx_n;
  logic            vld_n;
  logic            to_n;
  logic [IDXW-1:0] win_idx;
  logic            win_found;
  logic            arb;
  logic            expire;

  rr_prio_enc u_enc (
    .req   (req),
    .ptr   (ptr),
    .idx   (win_idx),
    .found (win_found)
  );

  // Arbitrate when idle or when the current owner releases (done or forced).
  assign arb = (state == IDLE) || done || expire;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] hold_cnt;

  // Forced release once the grant has been held MAX_HOLD cycles without done.
  assign expire = (state == GRANT) && !done && (hold_cnt == CW'(MAX_HOLD - 1));

  // Hold counter: cleared on any new grant and while idle, counts held cycles otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if ((arb && win_found) || (state_n == IDLE)) begin
      hold_cnt <= '0;
    end else if (!done) begin
      hold_cnt <= hold_cnt + CW'(1);
    end
  end
`else
  assign expire = 1'b0;
`endif

  // Next-state and next-output computation; grant registers hold unless arbitrating.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt;
    idx_n   = gnt_idx;
    vld_n   = gnt_vld;
    to_n    = 1'b0;
    if (arb) begin
      to_n = expire;
      if (win_found) begin
        state_n = GRANT;
        gnt_n   = NREQ'(1) << win_idx;
        idx_n   = win_idx;
        vld_n   = 1'b1;
        ptr_n   = win_idx + IDXW'(1);
      end else begin
        state_n = IDLE;
        gnt_n   = '0;
        idx_n   = '0;
        vld_n   = 1'b0;
      end
    end
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      gnt     <= gnt_n;
      gnt_idx <= idx_n;
      gnt_vld <= vld_n;
      timeout <= to_n;
    end
  end

endmodule
